// File: rtl/snake_food_tracker_pkg.sv
// snake_pkg: board geometry, FSM encodings and LFSR constants shared by
// the snake food tracker, its status interface and its LFSR.
package snake_pkg;

  localparam int MAX_LEN   = 16;
  localparam int NUM_LEN   = 10;
  localparam int LEN_W     = 4;
  localparam int SCORE_W   = 8;
  localparam int WIDTH     = 32;
  localparam int HEIGHT    = 24;
  localparam int NUM_CELLS = WIDTH * HEIGHT;

  localparam logic [NUM_LEN-1:0] CELL_LIMIT = NUM_LEN'(NUM_CELLS);
  localparam logic [LEN_W-1:0]   INIT_LEN   = LEN_W'(4);
  localparam logic [LEN_W-1:0]   WIN_LEN    = LEN_W'(MAX_LEN - 1);
  localparam logic [NUM_LEN-1:0] FOOD_INIT  = NUM_LEN'(400);

  localparam int               LFSR_W     = 10;
  localparam int               LFSR_TAP_A = 9;
  localparam int               LFSR_TAP_B = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h2A5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_EVAL   = 3'd2;
  localparam logic [2:0] ST_PLACE  = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;

  function automatic logic [NUM_LEN-1:0] seg_at(
    input logic [MAX_LEN*NUM_LEN-1:0] v,
    input logic [LEN_W-1:0]           i
  );
    return v[int'(i)*NUM_LEN +: NUM_LEN];
  endfunction

endpackage

// File: rtl/snake_food_tracker_if.sv
// snake_food_tracker_if: step request from the movement block (master)
// and length/food/score status returned by the tracker (slave).
interface snake_food_tracker_if;
  import snake_pkg::*;

  logic                       step;
  logic [MAX_LEN*NUM_LEN-1:0] pos_num;
  logic [LEN_W-1:0]           len;
  logic [NUM_LEN-1:0]         food_pos;
  logic                       food_valid;
  logic [SCORE_W-1:0]         score;
  logic                       self_hit;
  logic                       win;
  logic                       busy;

  modport master (
    output step, pos_num,
    input  len, food_pos, food_valid, score, self_hit, win, busy
  );

  modport slave (
    input  step, pos_num,
    output len, food_pos, food_valid, score, self_hit, win, busy
  );

endinterface

// File: rtl/snake_lfsr.sv
// snake_lfsr: free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1.
// Steps on every clock regardless of what the tracker is doing.
module snake_lfsr
  import snake_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/snake_food_tracker.sv
// snake_food_tracker: checks each moved head against body and food,
// grows/scores on eating and relocates food to a free random cell.
module snake_food_tracker
  import snake_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  snake_food_tracker_if.slave bus
);

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [NUM_LEN-1:0] head_q, head_d;
  logic [NUM_LEN-1:0] cand_q, cand_d;
  logic [NUM_LEN-1:0] food_q, food_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               fv_q, fv_d;
  logic               hit_q, hit_d;
  logic               win_q, win_d;

  logic [LFSR_W-1:0]  rnd;
  logic [NUM_LEN-1:0] seg;
  logic [LEN_W-1:0]   len_inc;
  logic               st_idle, st_scan, st_eval, st_place, st_verify;

  snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (rnd)
  );

  assign seg       = seg_at(bus.pos_num, idx_q);
  assign len_inc   = len_q + LEN_W'(1);
  assign st_idle   = (state_q == ST_IDLE);
  assign st_scan   = (state_q == ST_SCAN);
  assign st_eval   = (state_q == ST_EVAL);
  assign st_place  = (state_q == ST_PLACE);
  assign st_verify = (state_q == ST_VERIFY);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    head_d  = head_q;
    cand_d  = cand_q;
    food_d  = food_q;
    score_d = score_q;
    fv_d    = fv_q;
    hit_d   = hit_q;
    win_d   = win_q;
    unique case (1'b1)
      st_idle: begin
        if (bus.step && !hit_q && !win_q) begin
          head_d  = seg_at(bus.pos_num, LEN_W'(0));
          idx_d   = LEN_W'(1);
          state_d = ST_SCAN;
        end
      end
      st_scan: begin
        if (idx_q == len_q) begin
          state_d = ST_EVAL;
        end else begin
          if (seg == head_q) hit_d = 1'b1;
          idx_d = idx_q + LEN_W'(1);
        end
      end
      st_eval: begin
        state_d = ST_IDLE;
        if (!hit_q && head_q == food_q) begin
          len_d = len_inc;
          fv_d  = 1'b0;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          // Reaching the last free slot ends the game with no food left.
          if (len_inc == WIN_LEN) win_d = 1'b1;
          else                    state_d = ST_PLACE;
        end
      end
      st_place: begin
        if (rnd < CELL_LIMIT) begin
          cand_d  = rnd;
          idx_d   = '0;
          state_d = ST_VERIFY;
        end
      end
      st_verify: begin
        if (seg == cand_q) begin
          state_d = ST_PLACE;
        end else if (idx_q == len_q - LEN_W'(1)) begin
          food_d  = cand_q;
          fv_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= INIT_LEN;
      head_q  <= '0;
      cand_q  <= '0;
      food_q  <= FOOD_INIT;
      score_q <= '0;
      fv_q    <= 1'b1;
      hit_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      head_q  <= head_d;
      cand_q  <= cand_d;
      food_q  <= food_d;
      score_q <= score_d;
      fv_q    <= fv_d;
      hit_q   <= hit_d;
      win_q   <= win_d;
    end
  end

  assign bus.len        = len_q;
  assign bus.food_pos   = food_q;
  assign bus.food_valid = fv_q;
  assign bus.score      = score_q;
  assign bus.self_hit   = hit_q;
  assign bus.win        = win_q;
  assign bus.busy       = !st_idle;

endmodule

// File: tb/tb_snake_food_tracker.sv
// tb_snake_food_tracker: randomized steps against a transaction-level
// model of the tracker, compared on every falling clock edge.
module tb_snake_food_tracker;
  import snake_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_food_tracker_if bus ();

  snake_food_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Random value seen by the block at the n-th edge after reset is tab[n-1].
  logic [9:0] tab [65536];

  // Transaction model: outputs before the step (o_*), after it (n_*),
  // and the edge numbers at which each change becomes visible.
  int cyc;
  int t0, t_eval, t_done, t_hit;
  int o_len, n_len, o_score, n_score, o_food, n_food;
  bit o_fv, eat, placed, o_hit, n_hit, o_win, n_win;

  function automatic int e_len(input int now);
    return (eat && now >= t_eval) ? n_len : o_len;
  endfunction
  function automatic int e_score(input int now);
    return (eat && now >= t_eval) ? n_score : o_score;
  endfunction
  function automatic int e_food(input int now);
    return (placed && now >= t_done) ? n_food : o_food;
  endfunction
  function automatic bit e_fv(input int now);
    if (placed && now >= t_done) return 1'b1;
    if (eat && now >= t_eval) return 1'b0;
    return o_fv;
  endfunction
  function automatic bit e_hit(input int now);
    return o_hit | (n_hit && now >= t_hit);
  endfunction
  function automatic bit e_win(input int now);
    return o_win | (n_win && now >= t_eval);
  endfunction
  function automatic bit e_busy(input int now);
    return (now >= t0) && (now < t_done);
  endfunction

  function automatic int seg(input int k);
    return int'(bus.pos_num[k*10 +: 10]);
  endfunction

  function automatic bit in_body(input logic [9:0] v, input int n);
    for (int k = 0; k < n; k++)
      if (bus.pos_num[k*10 +: 10] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int wrap(input int v);
    return ((v % 768) + 768) % 768;
  endfunction

  function automatic int rand_stride();
    case ($urandom_range(0, 3))
      0:       return 1;
      1:       return -1;
      2:       return 32;
      default: return -32;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0; t0 = 0; t_eval = 0; t_done = 0; t_hit = 0;
    o_len = 4; n_len = 4; o_score = 0; n_score = 0;
    o_food = 400; n_food = 400; o_fv = 1'b1;
    eat = 1'b0; placed = 1'b0;
    o_hit = 1'b0; n_hit = 1'b0; o_win = 1'b0; n_win = 1'b0;
  endtask

  task automatic plan(input int now0);
    int l_len, l_score, l_food, l, hd, p, hi;
    bit l_fv, l_hit, l_win;
    l_len = e_len(now0); l_score = e_score(now0); l_food = e_food(now0);
    l_fv = e_fv(now0); l_hit = e_hit(now0); l_win = e_win(now0);
    o_len = l_len; o_score = l_score; o_food = l_food;
    o_fv = l_fv; o_hit = l_hit; o_win = l_win;
    eat = 1'b0; placed = 1'b0; n_hit = 1'b0; n_win = 1'b0;
    t0 = now0 + 1;
    l = o_len;
    hd = seg(0);
    for (int k = 1; k < l; k++)
      if (!n_hit && seg(k) == hd) begin n_hit = 1'b1; t_hit = t0 + k; end
    t_eval = t0 + l + 1;
    t_done = t_eval;
    if (!n_hit && hd == o_food) begin
      eat = 1'b1;
      n_len = l + 1;
      n_score = (o_score == 255) ? 255 : o_score + 1;
      if (n_len == 15) n_win = 1'b1;
      else begin
        p = t_eval + 1;
        for (int g = 0; g < 20000 && !placed; g++) begin
          if (tab[p-1] >= 10'd768) p++;
          else begin
            hi = -1;
            for (int k = 0; k < n_len; k++)
              if (hi < 0 && seg(k) == int'(tab[p-1])) hi = k;
            if (hi < 0) begin
              placed = 1'b1; n_food = int'(tab[p-1]); t_done = p + n_len;
            end else p = p + hi + 2;
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        if (bus.step === 1'b1 && !e_busy(cyc) && !e_hit(cyc) && !e_win(cyc))
          plan(cyc);
        cyc = cyc + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("len",        32'(bus.len),        32'(e_len(cyc)));
      check("score",      32'(bus.score),      32'(e_score(cyc)));
      check("food_pos",   32'(bus.food_pos),   32'(e_food(cyc)));
      check("food_valid", 32'(bus.food_valid), 32'(e_fv(cyc)));
      check("self_hit",   32'(bus.self_hit),   32'(e_hit(cyc)));
      check("win",        32'(bus.win),        32'(e_win(cyc)));
      check("busy",       32'(bus.busy),       32'(e_busy(cyc)));
    end
  end

  task automatic rst_checks();
    check("rst_len",   32'(bus.len),        32'd4);
    check("rst_food",  32'(bus.food_pos),   32'd400);
    check("rst_fv",    32'(bus.food_valid), 32'd1);
    check("rst_score", 32'(bus.score),      32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_hit",   32'(bus.self_hit),   32'd0);
    check("rst_win",   32'(bus.win),        32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1 rst_checks();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_segs(input int head, input int stride);
    for (int i = 0; i < 16; i++)
      bus.pos_num[i*10 +: 10] = 10'(wrap(head + i * stride));
  endtask

  // Called on a falling edge; returns the number of cycles busy was seen high.
  task automatic run_step(output int bc);
    int g;
    bc = 0; g = 0;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    if (bus.busy === 1'b1) bc++;
    while (e_busy(cyc) && g < 4000) begin
      @(negedge clk);
      g++;
      if (bus.busy === 1'b1) bc++;
    end
    if (g >= 4000) begin
      n_tests++; n_fail++;
      $display("FAIL step_timeout: busy after %0d cycles, want idle", g);
    end
  endtask

  function automatic int free_head(input int f);
    int h;
    h = $urandom_range(0, 767);
    return (h == f) ? wrap(h + 1) : h;
  endfunction

  initial begin
    int b, l, hd, g;
    logic [9:0] v;
    v = 10'h2A5;
    for (int i = 0; i < 65536; i++) begin
      tab[i] = v;
      v = {v[8:0], ^(v & 10'h240)};
    end
    bus.step = 1'b0;
    bus.pos_num = '0;

    do_reset();
    chk_en = 1'b1;

    load_segs(5, -1);
    run_step(b);
    check("plain_busy",  32'(b),            32'd5);
    check("plain_len",   32'(bus.len),      32'd4);
    check("plain_score", 32'(bus.score),    32'd0);
    check("plain_food",  32'(bus.food_pos), 32'd400);

    load_segs(400, -1);
    run_step(b);
    check("eat_score", 32'(bus.score),      32'd1);
    check("eat_len",   32'(bus.len),        32'd5);
    check("eat_fv",    32'(bus.food_valid), 32'd1);
    check("eat_range", 32'(bus.food_pos < 10'd768), 32'd1);
    check("eat_free",  32'(in_body(bus.food_pos, 5)), 32'd0);

    // Time the step so the first candidate drawn is off the board.
    l = e_len(cyc);
    load_segs(e_food(cyc), rand_stride());
    g = 0;
    while (tab[cyc + l + 2] < 10'd768 && g < 2000) begin
      @(negedge clk); g++;
    end
    run_step(b);
    check("reject_cost", 32'(b >= 2 * l + 4), 32'd1);
    check("reject_free", 32'(in_body(bus.food_pos, l + 1)), 32'd0);

    l = e_len(cyc);
    load_segs(free_head(e_food(cyc)), rand_stride());
    bus.step = 1'b1;
    b = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.step = (i == 1);
      if (bus.busy === 1'b1) b++;
    end
    g = 0;
    while (e_busy(cyc) && g < 100) begin
      @(negedge clk); g++;
      if (bus.busy === 1'b1) b++;
    end
    check("ignore_busy", 32'(b),       32'(l + 1));
    check("ignore_len",  32'(bus.len), 32'(l));

    load_segs(e_food(cyc), rand_stride());
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    g = 0;
    while (cyc < t_eval && g < 100) begin
      @(negedge clk); g++;
    end
    check("place_busy", 32'(bus.busy),       32'd1);
    check("place_fv",   32'(bus.food_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 rst_checks();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (e_len(cyc) < 12 && $urandom_range(0, 1) == 1) hd = e_food(cyc);
      else hd = free_head(e_food(cyc));
      load_segs(hd, rand_stride());
      run_step(b);
    end

    do_reset();
    bus.pos_num[0*10 +: 10] = 10'd10;
    bus.pos_num[1*10 +: 10] = 10'd11;
    bus.pos_num[2*10 +: 10] = 10'd43;
    bus.pos_num[3*10 +: 10] = 10'd10;
    for (int i = 4; i < 16; i++) bus.pos_num[i*10 +: 10] = 10'(200 + i);
    run_step(b);
    check("hit_flag",  32'(bus.self_hit), 32'd1);
    check("hit_busy",  32'(b),            32'd5);
    check("hit_score", 32'(bus.score),    32'd0);
    run_step(b);
    check("frozen_busy", 32'(b),              32'd0);
    check("frozen_hit",  32'(bus.self_hit),   32'd1);
    check("frozen_len",  32'(bus.len),        32'd4);
    check("frozen_food", 32'(bus.food_pos),   32'd400);
    check("frozen_fv",   32'(bus.food_valid), 32'd1);

    do_reset();
    for (int it = 0; it < 11; it++) begin
      load_segs(e_food(cyc), rand_stride());
      run_step(b);
    end
    check("win_len",   32'(bus.len),        32'd15);
    check("win_flag",  32'(bus.win),        32'd1);
    check("win_fv",    32'(bus.food_valid), 32'd0);
    check("win_score", 32'(bus.score),      32'd11);
    load_segs(free_head(e_food(cyc)), 1);
    run_step(b);
    check("win_frozen_busy",  32'(b),         32'd0);
    check("win_frozen_score", 32'(bus.score), 32'd11);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
